// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM state, grant owner and line-offset helpers for the memory bus arbiter.
package mem_bus_arbiter_pkg;
    localparam int LINE_WORDS_DEF = 8;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    function automatic int off_w(input int lw);
        return $clog2(lw) + 2;
    endfunction
    localparam int OFF_W = off_w(LINE_WORDS_DEF);
    function automatic logic [31:0] line_base(input logic [31:0] a, input int lw);
        return a & ~((32'd1 << off_w(lw)) - 32'd1);
    endfunction
endpackage

// File: rtl/mem_arb_beat_ctr.sv
// mem_arb_beat_ctr: latches the line base on grant and steps the beat word address on each ack.
module mem_arb_beat_ctr import mem_bus_arbiter_pkg::*; #(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] addr_in,
    input  logic        adv,
    output logic [31:0] addr,
    output logic        last
);
    localparam int CW = $clog2(LINE_WORDS);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   base_q, base_d;
    always_comb begin
        base_d = load ? line_base(addr_in, LINE_WORDS) : base_q;
        cnt_d  = load ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            base_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
        end
    end
    assign last = cnt_q == CW'(LINE_WORDS - 1);
    assign addr = base_q + 32'({cnt_q, 2'b00});
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a burst memory port between I-cache and D-cache with bounded D priority.
// Optional MEM_BUS_ARB_PERF_EN adds saturating line and wait-cycle counters.
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
    parameter int LINE_WORDS = 8,
    parameter int D_STREAK   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
`ifdef MEM_BUS_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_lines,
    output logic [31:0] perf_d_lines,
    output logic [31:0] perf_wait_cyc
`endif
);
    localparam int SW = $clog2(D_STREAK + 1);
    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          go_i, go_d, in_i, in_d, last;
    logic [31:0]   beat_addr;
    assign go_d = state_q == IDLE && d_req && (!i_req || streak_q < SW'(D_STREAK));
    assign go_i = state_q == IDLE && !go_d && i_req;
    assign in_i = state_q == GNT_I;
    assign in_d = state_q == GNT_D;
    always_comb begin
        state_d  = go_d ? GNT_D : go_i ? GNT_I :
                   (mem_req && mem_ack && last) ? DONE :
                   state_q == DONE ? IDLE : state_q;
        streak_d = (go_i || !i_req) ? '0 : go_d ? streak_q + SW'(1) : streak_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end
    mem_arb_beat_ctr #(.LINE_WORDS(LINE_WORDS)) u_beat (
        .clk     (clk),
        .rst     (rst),
        .load    (go_i || go_d),
        .addr_in (go_d ? d_addr : i_addr),
        .adv     (i_rvalid || d_rvalid),
        .addr    (beat_addr),
        .last    (last)
    );
    assign i_rvalid  = in_i && mem_ack;
    assign d_rvalid  = in_d && mem_ack;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign i_done    = i_rvalid && last;
    assign d_done    = d_rvalid && last;
    assign mem_req   = in_i || in_d;
    assign mem_we    = in_d && d_we;
    assign mem_addr  = mem_req ? beat_addr : '0;
    assign mem_wdata = mem_we ? d_wdata : '0;
    assign d_wready  = mem_we && mem_ack;
    // gated by reset so every output reads 0 while reset is held
    assign stall_if  = rst && i_req && !i_done;
    assign stall_mem = rst && d_req && !d_done;
`ifdef MEM_BUS_ARB_PERF_EN
    owner_t      owner_q, owner_d;
    logic [31:0] pil_q, pil_d, pdl_q, pdl_d, pwc_q, pwc_d;
    logic        i_wait, d_wait;
    assign i_wait = i_req && !(go_i || in_i || (state_q == DONE && owner_q == OWN_I));
    assign d_wait = d_req && !(go_d || in_d || (state_q == DONE && owner_q == OWN_D));
    always_comb begin
        owner_d = go_d ? OWN_D : go_i ? OWN_I : owner_q;
        pil_d   = pil_q + 32'((pil_q != '1) && i_done);
        pdl_d   = pdl_q + 32'((pdl_q != '1) && d_done);
        pwc_d   = pwc_q + 32'((pwc_q != '1) && (i_wait || d_wait));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_I;
            pil_q   <= '0;
            pdl_q   <= '0;
            pwc_q   <= '0;
        end else begin
            owner_q <= owner_d;
            pil_q   <= pil_d;
            pdl_q   <= pdl_d;
            pwc_q   <= pwc_d;
        end
    end
    assign perf_i_lines  = pil_q;
    assign perf_d_lines  = pdl_q;
    assign perf_wait_cyc = pwc_q;
`endif
    a_i_held: assert property (@(posedge clk) disable iff (!rst) in_i |-> i_req);
    a_d_held: assert property (@(posedge clk) disable iff (!rst) in_d |-> d_req);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven and sequence checks for mem_bus_arbiter.
module tb_mem_bus_arbiter;
    logic        clk, rst_n;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_rvalid, i_done, d_wready, d_rvalid, d_done;
    logic        mem_req, mem_we, stall_if, stall_mem;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_i_lines, perf_d_lines, perf_wait_cyc;
`endif
    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.LINE_WORDS(8), .D_STREAK(4)) dut (
        .clk(clk), .rst(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_BUS_ARB_PERF_EN
        , .perf_i_lines(perf_i_lines), .perf_d_lines(perf_d_lines), .perf_wait_cyc(perf_wait_cyc)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic ir, dr;
        logic [31:0] ia, da;
        logic mreq;
        logic [31:0] maddr;
        logic irv, idone, drv, ddone, sif, smem;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({mem_req, mem_we, i_rvalid, i_done, d_rvalid, d_done,
                               d_wready, stall_if, stall_mem}), 32'd0);
        chk({tag, "_maddr"}, mem_addr, 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
        chk({tag, "_irdata"}, i_rdata, 32'd0);
        chk({tag, "_drdata"}, d_rdata, 32'd0);
    endtask

    task automatic add(input logic ir, dr, input logic [31:0] ia, da, input logic mreq,
                       input logic [31:0] maddr, input logic irv, idone, drv, ddone, sif, smem);
        tbl.push_back('{ir, dr, ia, da, mreq, maddr, irv, idone, drv, ddone, sif, smem});
    endtask

    initial begin
        logic [5:0] order;
        int n, w, nwr;
        logic done_seen;
        rst_n = 0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 32'hDEAD_BEEF;
        // test 1: I only, line 0x100
        add(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 32'h104, 0, 1, 32'h100 + 32'(4 * k), 1, k == 7, 0, 0, k != 7, 0);
        add(0, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // test 2: simultaneous, D first, I granted after DONE and IDLE
        add(1, 1, 32'h30C, 32'h2044, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 8; k++)
            add(1, 1, 32'h30C, 32'h2044, 1, 32'h2040 + 32'(4 * k), 0, 0, 1, k == 7, 1, k != 7);
        add(1, 0, 32'h30C, 32'h2044, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 32'h30C, 32'h2044, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 32'h30C, 32'h2044, 1, 32'h300 + 32'(4 * k), 1, k == 7, 0, 0, k != 7, 0);
        add(0, 0, 32'h30C, 32'h2044, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 32'h30C, 32'h2044, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #2 chk_zero("reset");
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            i_req = tbl[i].ir; d_req = tbl[i].dr;
            i_addr = tbl[i].ia; d_addr = tbl[i].da;
            mem_rdata = 32'hC0DE_0000 + 32'(i);
            #2;
            chk($sformatf("v%0d_mreq", i), 32'(mem_req), 32'(tbl[i].mreq));
            if (tbl[i].mreq) chk($sformatf("v%0d_maddr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("v%0d_mwe", i), 32'(mem_we), 32'd0);
            chk($sformatf("v%0d_irv", i), 32'(i_rvalid), 32'(tbl[i].irv));
            chk($sformatf("v%0d_idone", i), 32'(i_done), 32'(tbl[i].idone));
            chk($sformatf("v%0d_drv", i), 32'(d_rvalid), 32'(tbl[i].drv));
            chk($sformatf("v%0d_ddone", i), 32'(d_done), 32'(tbl[i].ddone));
            chk($sformatf("v%0d_sif", i), 32'(stall_if), 32'(tbl[i].sif));
            chk($sformatf("v%0d_smem", i), 32'(stall_mem), 32'(tbl[i].smem));
            if (tbl[i].irv) chk($sformatf("v%0d_irdata", i), i_rdata, 32'hC0DE_0000 + 32'(i));
            if (tbl[i].drv) chk($sformatf("v%0d_drdata", i), d_rdata, 32'hC0DE_0000 + 32'(i));
        end
`ifdef MEM_BUS_ARB_PERF_EN
        chk("perf_i_lines", perf_i_lines, 32'd2);
        chk("perf_d_lines", perf_d_lines, 32'd1);
        chk("perf_wait_cyc", perf_wait_cyc, 32'd10);
`endif

        // test 3: writeback with an ack every third cycle
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h4008; mem_ack = 0; w = 0; nwr = 0;
        d_wdata = 32'hA500_0000;
        #2 chk("wb_idle_mreq", 32'(mem_req), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            mem_ack = (c % 3 == 2);
            d_wdata = 32'hA500_0000 + 32'(w);
            #2;
            chk($sformatf("wb%0d_mreq", c), 32'(mem_req), 32'd1);
            chk($sformatf("wb%0d_mwe", c), 32'(mem_we), 32'd1);
            chk($sformatf("wb%0d_maddr", c), mem_addr, 32'h4000 + 32'(4 * w));
            chk($sformatf("wb%0d_mwdata", c), mem_wdata, 32'hA500_0000 + 32'(w));
            chk($sformatf("wb%0d_wready", c), 32'(d_wready), 32'(mem_ack));
            if (mem_ack) begin
                nwr++;
                chk($sformatf("wb%0d_ddone", c), 32'(d_done), 32'(w == 7));
                done_seen = (w == 7);
                w++;
            end
        end
        chk("wb_done_seen", 32'(done_seen), 32'd1);
        chk("wb_wready_count", 32'(nwr), 32'd8);
        @(negedge clk);
        d_req = 0; d_we = 0; mem_ack = 0;
        #2 chk("wb_after_mreq", 32'(mem_req), 32'd0);
        @(negedge clk);

        // test 4: starvation bound, D held back-to-back against a waiting I
        @(negedge clk);
        i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h2000; mem_ack = 1;
        order = '0; n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            @(negedge clk);
            #2;
            if (i_done) begin order[n] = 1'b1; n++; end
            else if (d_done) n++;
        end
        chk("starve_count", 32'(n), 32'd6);
        chk("starve_order", 32'(order), 32'b010000);
        @(negedge clk);
        i_req = 0; d_req = 0; mem_ack = 0;
        @(negedge clk);
        @(negedge clk);

        // test 5: reset at beat 3 aborts the burst
        @(negedge clk);
        i_req = 1; i_addr = 32'h500; mem_ack = 1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #2 chk("rst_beat3_addr", mem_addr, 32'h50C);
        rst_n = 0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        #2 chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1;
        #2 chk("rst_rel_mreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        #2 chk("rst_new_mreq", 32'(mem_req), 32'd1);
        chk("rst_new_addr", mem_addr, 32'h500);
        done_seen = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            done_seen = i_done;
            if (!done_seen) begin @(negedge clk); #2; end
        end
        chk("rst_new_done", 32'(done_seen), 32'd1);
        @(negedge clk);
        i_req = 0; mem_ack = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
